// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART receive sniffer.
// Optional even-parity framing is selected with UART_RX_PARITY_EN.
package uart_pkg;

  localparam int unsigned BYTE_W = 8;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    BREAK
  } rx_state_e;

  // Clock cycles per oversample tick, rounded to nearest, never below 1.
  function automatic int unsigned calc_div(input int unsigned clk_hz,
                                           input int unsigned baud,
                                           input int unsigned os);
    int unsigned d;
    int unsigned q;
    d = baud * os;
    if (d == 0) return 1;
    q = (clk_hz + d / 2) / d;
    return (q == 0) ? 1 : q;
  endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// First-word-fall-through byte FIFO with push/pop and full/empty flags.
// A push while full is ignored unless a pop happens in the same cycle.
module uart_rx_fifo #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             empty,
  output logic             full
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_q;
  logic [AW-1:0]    rd_q;
  logic [CW-1:0]    count_q;
  logic             pop_ok;
  logic             push_ok;

  assign empty    = (count_q == '0);
  assign full     = (count_q == CW'(DEPTH));
  assign pop_ok   = pop && !empty;
  assign push_ok  = push && (!full || pop_ok);
  assign pop_data = empty ? '0 : mem_q[rd_q];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
    end else begin
      if (push_ok) wr_q <= wr_q + AW'(1);
      if (pop_ok)  rd_q <= rd_q + AW'(1);
      count_q <= count_q + CW'(push_ok) - CW'(pop_ok);
    end
  end

  // Storage carries no reset; the read mux hides stale contents while empty.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_q] <= push_data;
  end

endmodule

// File: rtl/uart_rx_sniffer.sv
// Oversampling UART receiver feeding a FWFT byte FIFO with valid/ready pop.
// Define UART_RX_PARITY_EN for 8E1 framing; default build is 8N1.
module uart_rx_sniffer
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ_HZ = 125_000_000,
  parameter int unsigned BAUD        = 115200,
  parameter int unsigned OVERSAMPLE  = 16,
  parameter int unsigned FIFO_DEPTH  = 16
) (
  input  logic              ref_clk,
  input  logic              reset,
  input  logic              uart_rx_i,
  output logic [BYTE_W-1:0] rx_data_o,
  output logic              rx_valid_o,
  input  logic              rx_ready_i,
  output logic              frame_err_o,
  output logic              parity_err_o,
  output logic              overflow_o,
  output logic              busy_o
);

  localparam int unsigned DIV   = calc_div(CLK_FREQ_HZ, BAUD, OVERSAMPLE);
  localparam int unsigned DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned OS_W  = $clog2(OVERSAMPLE);
  localparam int unsigned HALF  = OVERSAMPLE / 2;

  rx_state_e         state_q, state_d;
  logic [1:0]        sync_q;
  logic              rx_s;
  logic              rx_prev_q;
  logic [DIV_W-1:0]  div_q, div_d;
  logic [OS_W-1:0]   os_q, os_d;
  logic [2:0]        bit_q, bit_d;
  logic [BYTE_W-1:0] shift_q, shift_d;
  logic              frame_err_q, frame_err_d;
  logic              overflow_q, overflow_d;
  logic              busy_q, busy_d;
  logic              tick_c;
  logic              push_c;
  logic              fifo_empty;
  logic              fifo_full;
`ifdef UART_RX_PARITY_EN
  logic              par_bad_q, par_bad_d;
  logic              parity_err_q, parity_err_d;
`endif

  assign rx_s   = sync_q[1];
  assign tick_c = (state_q != IDLE) && (div_q == DIV_W'(DIV - 1));

  always_comb begin
    state_d     = state_q;
    div_d       = (state_q == IDLE || tick_c) ? '0 : div_q + DIV_W'(1);
    os_d        = tick_c ? os_q + OS_W'(1) : os_q;
    bit_d       = bit_q;
    shift_d     = shift_q;
    frame_err_d = 1'b0;
    push_c      = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_bad_d    = par_bad_q;
    parity_err_d = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        os_d  = '0;
        bit_d = '0;
`ifdef UART_RX_PARITY_EN
        par_bad_d = 1'b0;
`endif
        if (rx_prev_q && !rx_s) state_d = START;
      end
      START: begin
        // Mid-start-bit check rejects short low glitches.
        if (tick_c && os_q == OS_W'(HALF - 1)) begin
          os_d    = '0;
          state_d = rx_s ? IDLE : DATA;
        end
      end
      DATA: begin
        if (tick_c && os_q == OS_W'(OVERSAMPLE - 1)) begin
          os_d    = '0;
          shift_d = {rx_s, shift_q[BYTE_W-1:1]};
          bit_d   = bit_q + 3'd1;
`ifdef UART_RX_PARITY_EN
          if (bit_q == 3'd7) state_d = PARITY;
`else
          if (bit_q == 3'd7) state_d = STOP;
`endif
        end
      end
      PARITY: begin
`ifdef UART_RX_PARITY_EN
        if (tick_c && os_q == OS_W'(OVERSAMPLE - 1)) begin
          os_d         = '0;
          par_bad_d    = ((^shift_q) != rx_s);
          parity_err_d = par_bad_d;
          state_d      = STOP;
        end
`else
        state_d = IDLE;
`endif
      end
      STOP: begin
        if (tick_c && os_q == OS_W'(OVERSAMPLE - 1)) begin
          os_d = '0;
          if (rx_s) begin
`ifdef UART_RX_PARITY_EN
            push_c = !par_bad_q;
`else
            push_c = 1'b1;
`endif
            state_d = IDLE;
          end else begin
            frame_err_d = 1'b1;
            state_d     = BREAK;
          end
        end
      end
      BREAK: begin
        os_d = '0;
        if (rx_s) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    overflow_d = push_c && fifo_full && !rx_ready_i;
    busy_d     = (state_d != IDLE);
  end

  always_ff @(posedge ref_clk or posedge reset) begin
    if (reset) begin
      sync_q      <= 2'b11;
      rx_prev_q   <= 1'b1;
      state_q     <= IDLE;
      div_q       <= '0;
      os_q        <= '0;
      bit_q       <= '0;
      shift_q     <= '0;
      frame_err_q <= 1'b0;
      overflow_q  <= 1'b0;
      busy_q      <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bad_q    <= 1'b0;
      parity_err_q <= 1'b0;
`endif
    end else begin
      sync_q      <= {sync_q[0], uart_rx_i};
      rx_prev_q   <= rx_s;
      state_q     <= state_d;
      div_q       <= div_d;
      os_q        <= os_d;
      bit_q       <= bit_d;
      shift_q     <= shift_d;
      frame_err_q <= frame_err_d;
      overflow_q  <= overflow_d;
      busy_q      <= busy_d;
`ifdef UART_RX_PARITY_EN
      par_bad_q    <= par_bad_d;
      parity_err_q <= parity_err_d;
`endif
    end
  end

  uart_rx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (BYTE_W)
  ) u_fifo (
    .clk       (ref_clk),
    .rst       (reset),
    .push      (push_c),
    .push_data (shift_q),
    .pop       (rx_ready_i),
    .pop_data  (rx_data_o),
    .empty     (fifo_empty),
    .full      (fifo_full)
  );

  assign rx_valid_o  = !fifo_empty;
  assign frame_err_o = frame_err_q;
  assign overflow_o  = overflow_q;
  assign busy_o      = busy_q;
`ifdef UART_RX_PARITY_EN
  assign parity_err_o = parity_err_q;
`else
  assign parity_err_o = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_sniffer.sv
// Self-checking bench for uart_rx_sniffer at 16 clocks per bit (DIV=1).
// Honours UART_RX_PARITY_EN to send 8E1 frames and run the parity sequence.
module tb_uart_rx_sniffer;

  localparam int unsigned BIT = 16;

  logic       ref_clk = 1'b0;
  logic       reset = 1'b1;
  logic       uart_rx = 1'b1;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready = 1'b1;
  logic       frame_err;
  logic       parity_err;
  logic       overflow;
  logic       busy;

  typedef struct {
    logic [7:0] data;
    logic       stop_bit;
    logic       exp_push;
    int         exp_ferr;
  } vec_t;

  int         checks = 0;
  int         errors = 0;
  int         ferr_cnt = 0;
  int         perr_cnt = 0;
  int         ovf_cnt = 0;
  logic [7:0] exp_q[$];

  always #5 ref_clk = ~ref_clk;

  uart_rx_sniffer #(
    .CLK_FREQ_HZ (1_600_000),
    .BAUD        (100_000),
    .OVERSAMPLE  (16),
    .FIFO_DEPTH  (16)
  ) dut (
    .ref_clk      (ref_clk),
    .reset        (reset),
    .uart_rx_i    (uart_rx),
    .rx_data_o    (rx_data),
    .rx_valid_o   (rx_valid),
    .rx_ready_i   (rx_ready),
    .frame_err_o  (frame_err),
    .parity_err_o (parity_err),
    .overflow_o   (overflow),
    .busy_o       (busy)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(posedge ref_clk);
    #1;
  endtask

  task automatic send_bits(input logic [11:0] bits, input int n);
    for (int i = 0; i < n; i++) begin
      uart_rx = bits[i];
      wait_clks(BIT);
    end
  endtask

  // A zero stop bit is followed by one more low bit, then idle.
  task automatic send_frame(input logic [7:0] d, input logic stop_bit);
    logic [11:0] bits;
    int          n;
`ifdef UART_RX_PARITY_EN
    bits = {1'b0, stop_bit, ^d, d, 1'b0};
    n    = 11;
`else
    bits = {2'b00, stop_bit, d, 1'b0};
    n    = 10;
`endif
    send_bits(bits, n);
    if (!stop_bit) begin
      uart_rx = 1'b0;
      wait_clks(BIT);
    end
    uart_rx = 1'b1;
    wait_clks(2 * BIT);
  endtask

  task automatic wait_drain(input string name);
    for (int i = 0; i < 64 && exp_q.size() != 0; i++) wait_clks(1);
    check(name, exp_q.size(), 0);
  endtask

  // Scoreboard side: pops happen at the next rising edge when valid && ready.
  task automatic monitor();
    logic [7:0] exp;
    forever begin
      @(negedge ref_clk);
      if (frame_err)  ferr_cnt++;
      if (parity_err) perr_cnt++;
      if (overflow)   ovf_cnt++;
      if (rx_valid && rx_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_byte actual=%02h required=none", rx_data);
        end else begin
          exp = exp_q.pop_front();
          check("rx_byte", rx_data, exp);
        end
      end
    end
  endtask

  initial begin
    vec_t vecs[8];
    int   f0;
    int   o0;
    int   p0;
    int   k;

    vecs[0] = '{data: 8'h55, stop_bit: 1'b1, exp_push: 1'b1, exp_ferr: 0};
    vecs[1] = '{data: 8'hA3, stop_bit: 1'b0, exp_push: 1'b0, exp_ferr: 1};
    vecs[2] = '{data: 8'h3C, stop_bit: 1'b1, exp_push: 1'b1, exp_ferr: 0};
    vecs[3] = '{data: 8'h00, stop_bit: 1'b1, exp_push: 1'b1, exp_ferr: 0};
    vecs[4] = '{data: 8'hFF, stop_bit: 1'b1, exp_push: 1'b1, exp_ferr: 0};
    vecs[5] = '{data: 8'h80, stop_bit: 1'b0, exp_push: 1'b0, exp_ferr: 1};
    vecs[6] = '{data: 8'h01, stop_bit: 1'b1, exp_push: 1'b1, exp_ferr: 0};
    vecs[7] = '{data: 8'hC9, stop_bit: 1'b1, exp_push: 1'b1, exp_ferr: 0};

    fork
      monitor();
      begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "bench timeout");
      end
    join_none

    // Reset state.
    wait_clks(3);
    check("reset_valid", rx_valid, 0);
    check("reset_data", rx_data, 0);
    check("reset_busy", busy, 0);
    check("reset_frame_err", frame_err, 0);
    check("reset_parity_err", parity_err, 0);
    check("reset_overflow", overflow, 0);
    reset = 1'b0;
    wait_clks(4);

    // Table of frames, including stop-bit errors followed by good bytes.
    foreach (vecs[i]) begin
      f0 = ferr_cnt;
      if (vecs[i].exp_push) exp_q.push_back(vecs[i].data);
      send_frame(vecs[i].data, vecs[i].stop_bit);
      wait_drain("byte_drain");
      check("frame_err_count", ferr_cnt - f0, vecs[i].exp_ferr);
      check("busy_idle", busy, 0);
    end
    check("table_parity_pulses", perr_cnt, 0);
    check("table_overflow_pulses", ovf_cnt, 0);

    // Short low glitch on the line.
    f0 = ferr_cnt;
    uart_rx = 1'b0;
    wait_clks(4);
    check("glitch_busy_high", busy, 1);
    uart_rx = 1'b1;
    k = 0;
    while (busy && k < 16) begin
      wait_clks(1);
      k++;
    end
    check("glitch_busy_low", busy, 0);
    wait_clks(2 * BIT);
    check("glitch_no_byte", rx_valid, 0);
    check("glitch_no_ferr", ferr_cnt - f0, 0);

    // Overflow: 17 bytes into a 16-entry FIFO with no pops.
    rx_ready = 1'b0;
    o0 = ovf_cnt;
    for (int b = 0; b < 17; b++) begin
      if (b < 16) exp_q.push_back(8'(b));
      send_frame(8'(b), 1'b1);
    end
    check("overflow_pulses", ovf_cnt - o0, 1);
    check("full_valid", rx_valid, 1);
    check("full_head", rx_data, 8'h00);
    rx_ready = 1'b1;
    wait_drain("fifo_drain");
    wait_clks(2);
    check("fifo_empty_after", rx_valid, 0);

    // Reset during data bit 3 of 0x81, then a clean 0x7E.
    f0 = ferr_cnt;
    o0 = ovf_cnt;
    p0 = perr_cnt;
    send_bits(12'h002, 4);
    uart_rx = 1'b0;
    wait_clks(8);
    reset = 1'b1;
    wait_clks(3);
    check("midreset_busy", busy, 0);
    check("midreset_valid", rx_valid, 0);
    uart_rx = 1'b1;
    reset = 1'b0;
    wait_clks(2 * BIT);
    exp_q.push_back(8'h7E);
    send_frame(8'h7E, 1'b1);
    wait_drain("midreset_drain");
    check("midreset_ferr", ferr_cnt - f0, 0);
    check("midreset_ovf", ovf_cnt - o0, 0);
    check("midreset_perr", perr_cnt - p0, 0);

`ifdef UART_RX_PARITY_EN
    // 0x07 has odd weight, so the even-parity bit must be 1.
    f0 = ferr_cnt;
    p0 = perr_cnt;
    send_bits({1'b0, 1'b1, 1'b0, 8'h07, 1'b0}, 11);
    uart_rx = 1'b1;
    wait_clks(2 * BIT);
    check("bad_parity_pulse", perr_cnt - p0, 1);
    check("bad_parity_no_byte", rx_valid, 0);
    check("bad_parity_no_ferr", ferr_cnt - f0, 0);
    exp_q.push_back(8'h07);
    send_frame(8'h07, 1'b1);
    wait_drain("good_parity_drain");
    check("good_parity_no_pulse", perr_cnt - p0, 1);
`else
    check("parity_tied_low", perr_cnt, 0);
`endif

    check("scoreboard_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
